// File: rtl/mem_arbiter_2p.sv
// Two-port arbiter/sequencer for a single-port RAM: one access at a time,
// registered RAM pins, registered read data and a one-cycle ACK per access.
module mem_arbiter_2p #(
    parameter int AW         = 14,
    parameter int DW         = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0,
    input  logic          i_we0,
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_wdata0,
    output logic          o_ack0,
    output logic [DW-1:0] o_rdata0,
    input  logic          i_req1,
    input  logic          i_we1,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_ack1,
    output logic [DW-1:0] o_rdata1,
    output logic          o_ram_e,
    output logic          o_ram_w,
    output logic          o_ram_r,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_d,
    input  logic [DW-1:0] i_ram_q,
    output logic          o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          r_state, r_state_next;
    logic            r_sel, r_sel_next;
    logic            r_rr_last, r_rr_last_next;
    logic            r_ram_e, r_ram_e_next;
    logic            r_ram_w, r_ram_w_next;
    logic            r_ram_r, r_ram_r_next;
    logic [AW-1:0]   r_ram_addr, r_ram_addr_next;
    logic [DW-1:0]   r_ram_d, r_ram_d_next;
    logic [DW-1:0]   r_rdata [2];
    logic [1:0]      r_ack;

    logic            w_any_req;
    logic            w_gnt1;

    assign w_any_req = i_req0 | i_req1;
    // Port 1 wins when alone, or on a round-robin tie when port 0 was served last.
    assign w_gnt1 = i_req1 & (~i_req0 | ((FIXED_PRIO == 0) & ~r_rr_last));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 1'b0;
            r_rr_last  <= 1'b1;
            r_ram_e    <= 1'b0;
            r_ram_w    <= 1'b0;
            r_ram_r    <= 1'b0;
            r_ram_addr <= '0;
            r_ram_d    <= '0;
        end else begin
            r_state    <= r_state_next;
            r_sel      <= r_sel_next;
            r_rr_last  <= r_rr_last_next;
            r_ram_e    <= r_ram_e_next;
            r_ram_w    <= r_ram_w_next;
            r_ram_r    <= r_ram_r_next;
            r_ram_addr <= r_ram_addr_next;
            r_ram_d    <= r_ram_d_next;
        end
    end

    always_comb begin
        r_state_next    = r_state;
        r_sel_next      = r_sel;
        r_rr_last_next  = r_rr_last;
        r_ram_e_next    = r_ram_e;
        r_ram_w_next    = r_ram_w;
        r_ram_r_next    = r_ram_r;
        r_ram_addr_next = r_ram_addr;
        r_ram_d_next    = r_ram_d;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    r_state_next    = S_ACCESS;
                    r_sel_next      = w_gnt1;
                    r_rr_last_next  = w_gnt1;
                    r_ram_e_next    = 1'b1;
                    r_ram_w_next    = w_gnt1 ? i_we1 : i_we0;
                    r_ram_r_next    = w_gnt1 ? ~i_we1 : ~i_we0;
                    r_ram_addr_next = w_gnt1 ? i_addr1 : i_addr0;
                    r_ram_d_next    = w_gnt1 ? i_wdata1 : i_wdata0;
                end
            end
            S_ACCESS: begin
                r_state_next = S_DONE;
                r_ram_e_next = 1'b0;
                r_ram_w_next = 1'b0;
                r_ram_r_next = 1'b0;
            end
            S_DONE: begin
                r_state_next = S_IDLE;
            end
            default: begin
                r_state_next = S_IDLE;
            end
        endcase
    end

    // Per-port completion: only the selected port's ACK/RDATA ever move.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_rdata[gi] <= '0;
                r_ack[gi]   <= 1'b0;
            end else begin
                r_ack[gi] <= (r_state == S_ACCESS) && (r_sel == 1'(gi));
                if ((r_state == S_ACCESS) && r_ram_r && (r_sel == 1'(gi))) begin
                    r_rdata[gi] <= i_ram_q;
                end
            end
        end
    end

    assign o_ack0     = r_ack[0];
    assign o_ack1     = r_ack[1];
    assign o_rdata0   = r_rdata[0];
    assign o_rdata1   = r_rdata[1];
    assign o_ram_e    = r_ram_e;
    assign o_ram_w    = r_ram_w;
    assign o_ram_r    = r_ram_r;
    assign o_ram_addr = r_ram_addr;
    assign o_ram_d    = r_ram_d;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Bench for mem_arbiter_2p: round-robin and fixed-priority instances, each on
// its own RAM model, checked against a transaction-level reference model.
module tb_mem_arbiter_2p;
    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    always #5 clk = ~clk;

    // round-robin instance signals
    logic          req0, we0, req1, we1, ack0, ack1;
    logic [AW-1:0] addr0, addr1, ram_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, ram_d, ram_q;
    logic          ram_e, ram_w, ram_r, busy;
    // fixed-priority instance signals
    logic          f_req0, f_we0, f_req1, f_we1, f_ack0, f_ack1;
    logic [AW-1:0] f_addr0, f_addr1, f_ram_addr;
    logic [DW-1:0] f_wdata0, f_wdata1, f_rdata0, f_rdata1, f_ram_d, f_ram_q;
    logic          f_ram_e, f_ram_w, f_ram_r, f_busy;

    mem_arbiter_2p #(.AW(AW), .DW(DW), .FIXED_PRIO(0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .o_ack0(ack0), .o_rdata0(rdata0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_ack1(ack1), .o_rdata1(rdata1),
        .o_ram_e(ram_e), .o_ram_w(ram_w), .o_ram_r(ram_r),
        .o_ram_addr(ram_addr), .o_ram_d(ram_d), .i_ram_q(ram_q),
        .o_busy(busy)
    );

    mem_arbiter_2p #(.AW(AW), .DW(DW), .FIXED_PRIO(1)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_req0(f_req0), .i_we0(f_we0), .i_addr0(f_addr0), .i_wdata0(f_wdata0),
        .o_ack0(f_ack0), .o_rdata0(f_rdata0),
        .i_req1(f_req1), .i_we1(f_we1), .i_addr1(f_addr1), .i_wdata1(f_wdata1),
        .o_ack1(f_ack1), .o_rdata1(f_rdata1),
        .o_ram_e(f_ram_e), .o_ram_w(f_ram_w), .o_ram_r(f_ram_r),
        .o_ram_addr(f_ram_addr), .o_ram_d(f_ram_d), .i_ram_q(f_ram_q),
        .o_busy(f_busy)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return 16'((i * 37) ^ 16'h1357);
    endfunction

    // RAM models: combinational read, write on rising edge while E and W are high
    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] mem_f [DEPTH];
    assign ram_q   = mem_r[ram_addr];
    assign f_ram_q = mem_f[f_ram_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= pat(i);
                mem_f[i] <= pat(i);
            end
        end else begin
            if (ram_e && ram_w)     mem_r[ram_addr]   <= ram_d;
            if (f_ram_e && f_ram_w) mem_f[f_ram_addr] <= f_ram_d;
        end
    end

    // reference model state
    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] exp_rd [2];
    int            last_grant;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One arbitration round: requests presented together, each port held until its ACK.
    task automatic round(input logic q0, input logic q1, input logic w0, input logic w1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int            t [2];
        logic          w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        int            first, p;
        t[0] = -10; t[1] = -10;
        w[0] = w0; w[1] = w1; a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        if (q0 && q1) first = (last_grant == 1) ? 0 : 1;
        else          first = q0 ? 0 : 1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1 && !(q0 && q1)) break;
            if (k == 0 && !(q0 || q1)) break;
            p = (k == 0) ? first : 1 - first;
            t[p] = 2 + 3 * k;
            last_grant = p;
            if (w[p]) shadow[a[p]] = d[p];
            else      exp_rd[p] = shadow[a[p]];
        end
        req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
            check("ack0", 32'(ack0), 32'(n == t[0]));
            check("ack1", 32'(ack1), 32'(n == t[1]));
            check("busy", 32'(busy), 32'(n == t[0] - 1 || n == t[0] || n == t[1] - 1 || n == t[1]));
            check("ram_e", 32'(ram_e), 32'(n == t[0] - 1 || n == t[1] - 1));
            for (int q = 0; q < 2; q++) begin
                if (n == t[q] - 1) begin
                    check("ram_w", 32'(ram_w), 32'(w[q]));
                    check("ram_r", 32'(ram_r), 32'(!w[q]));
                    check("ram_addr", 32'(ram_addr), 32'(a[q]));
                    if (w[q]) check("ram_d", 32'(ram_d), 32'(d[q]));
                end
            end
            if (n == t[0]) check("rdata0_ack", 32'(rdata0), 32'(exp_rd[0]));
            if (n == t[1]) check("rdata1_ack", 32'(rdata1), 32'(exp_rd[1]));
            if (n == t[0] + 1) req0 = 1'b0;
            if (n == t[1] + 1) req1 = 1'b0;
        end
        check("rdata0_hold", 32'(rdata0), 32'(exp_rd[0]));
        check("rdata1_hold", 32'(rdata1), 32'(exp_rd[1]));
        $display("round q=%0b%0b we=%0b%0b a0=%0d a1=%0d first=%0d rd0=%h rd1=%h",
                 q0, q1, w0, w1, a0, a1, first, rdata0, rdata1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'({ack0, ack1}), 32'(0));
        check({tag, "_rdata0"}, 32'(rdata0), 32'(0));
        check({tag, "_rdata1"}, 32'(rdata1), 32'(0));
        check({tag, "_ewrb"}, 32'({ram_e, ram_w, ram_r, busy}), 32'(0));
        check({tag, "_addr"}, 32'(ram_addr), 32'(0));
        check({tag, "_d"}, 32'(ram_d), 32'(0));
    endtask

    initial begin
        int            p;
        logic          q0, q1;
        logic [AW-1:0] ra0, ra1;
        rst = 1'b1; mem_init = 1'b1;
        {req0, we0, req1, we1} = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        {f_req0, f_we0, f_req1, f_we1} = '0; f_addr0 = '0; f_addr1 = '0;
        f_wdata0 = '0; f_wdata1 = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_grant = 1;

        @(posedge clk); #1;
        mem_init = 1'b0;
        check_reset_outputs("reset");
        check("fp_reset", 32'({f_ack0, f_ack1, f_ram_e, f_busy}), 32'(0));

        // continuous contention from the first edge after reset release
        @(posedge clk); #1;
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 14'd50; addr1 = 14'd60;
        for (int n = 1; n <= 13; n++) begin
            @(posedge clk); #1;
            p = -1;
            if (n <= 11 && n % 3 == 2) begin
                p = 1 - last_grant;
                last_grant = p;
                exp_rd[p] = shadow[(p == 0) ? 50 : 60];
            end
            check("rr_ack0", 32'(ack0), 32'(p == 0));
            check("rr_ack1", 32'(ack1), 32'(p == 1));
            check("rr_excl", 32'(ack0 & ack1), 32'(0));
            if (p == 0) check("rr_rdata0", 32'(rdata0), 32'(exp_rd[0]));
            if (p == 1) check("rr_rdata1", 32'(rdata1), 32'(exp_rd[1]));
            if (n == 12) begin req0 = 1'b0; req1 = 1'b0; end
            $display("rr cycle %0d ack0=%0b ack1=%0b", n, ack0, ack1);
        end

        // fixed priority: port 1 waits until port 0 stops requesting
        f_req0 = 1'b1; f_req1 = 1'b1; f_addr0 = 14'd70; f_addr1 = 14'd80;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            check("fp_ack0", 32'(f_ack0), 32'(n <= 11 && n % 3 == 2));
            check("fp_ack1", 32'(f_ack1), 32'(n == 14));
            if (f_ack0) check("fp_rdata0", 32'(f_rdata0), 32'(pat(70)));
            if (f_ack1) check("fp_rdata1", 32'(f_rdata1), 32'(pat(80)));
            if (n == 12) f_req0 = 1'b0;
            if (n == 15) f_req1 = 1'b0;
            $display("fp cycle %0d ack0=%0b ack1=%0b", n, f_ack0, f_ack1);
        end

        // reset in the middle of a write: nothing commits, outputs clear at once
        req0 = 1'b1; we0 = 1'b1; addr0 = 14'h0100; wdata0 = 16'hDEAD;
        @(posedge clk); #1;
        check("abort_ram_w", 32'(ram_w), 32'(1));
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b0; req0 = 1'b0; we0 = 1'b0;
        last_grant = 1; exp_rd[0] = '0; exp_rd[1] = '0;
        round(1, 0, 0, 0, 14'h0100, 0, 0, 0);

        // single port 0 write/read
        round(1, 0, 1, 0, 14'd1000, 0, 16'h00AA, 0);
        round(1, 0, 0, 0, 14'd1000, 0, 0, 0);
        // boundary addresses on port 1
        round(0, 1, 0, 1, 0, 14'd0, 0, 16'h1234);
        round(0, 1, 0, 1, 0, 14'd16383, 0, 16'hBEEF);
        round(0, 1, 0, 0, 0, 14'd0, 0, 0);
        round(0, 1, 0, 0, 0, 14'd16383, 0, 0);
        // cross-port coherence: port 0 served last, so port 1's write goes first
        round(1, 0, 0, 0, 14'd5, 0, 0, 0);
        round(1, 1, 0, 1, 14'd3000, 14'd3000, 0, 16'h5A5A);
        check("coherence", 32'(rdata0), 32'(16'h5A5A));

        // random rounds over a small hot region plus the extreme addresses
        for (int r = 0; r < 40; r++) begin
            q0 = 1'($urandom_range(0, 1));
            q1 = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       ra0 = 14'd0;
                1:       ra0 = 14'd16383;
                default: ra0 = 14'($urandom_range(0, 7));
            endcase
            ra1 = ($urandom_range(0, 1) == 1) ? ra0 : 14'($urandom_range(0, 7));
            round(q0, q1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra0, ra1,
                  16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
